// File: rtl/btflv_fp8_adder.sv
// -----------------------------------------------------------------------------
// btflv_fp8_adder
//
// Registered adder for two E4M3 floating-point values (1 sign, 4 exponent,
// 3 mantissa bits, bias 7). The format has no Inf/NaN encodings, so exponent
// 15 is an ordinary normal exponent and overflow saturates to the largest
// finite magnitude. Subnormals (exponent field 0) are supported on input and
// produced on output via gradual underflow. Rounding is round-to-nearest,
// ties-to-even. The sum appears on uo_out one clock after the operands.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  synchronous reset, active HIGH despite the name
//   ena      in   1  result register load enable
//   ui_in    in   8  operand A {sign, exp[3:0], mant[2:0]}
//   uio_in   in   8  operand B, same format
//   uo_out   out  8  registered sum {sign, exp[3:0], mant[2:0]}
//   uio_out  out  8  constant 0
//   uio_oe   out  8  constant 0 (bidirectional pins are all inputs)
// -----------------------------------------------------------------------------
module btflv_fp8_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Exponent used for arithmetic: subnormals share the scale of exponent 1.
  function automatic logic [3:0] eff_exp(input logic [3:0] e);
    logic [3:0] r;
    if (e == 4'd0) begin
      r = 4'd1;
    end else begin
      r = e;
    end
    return r;
  endfunction

  // Leading-zero count of a 7-bit value; 7 means the value is zero.
  function automatic logic [2:0] lzc7(input logic [6:0] v);
    logic [2:0] r;
    casez (v)
      7'b1??????: r = 3'd0;
      7'b01?????: r = 3'd1;
      7'b001????: r = 3'd2;
      7'b0001???: r = 3'd3;
      7'b00001??: r = 3'd4;
      7'b000001?: r = 3'd5;
      7'b0000001: r = 3'd6;
      default:    r = 3'd7;
    endcase
    return r;
  endfunction

  // Unpacked operands
  logic [3:0] a_sig_s, b_sig_s;
  logic [3:0] a_eff_s, b_eff_s;

  // Ordered operands: l_* has the larger magnitude
  logic       l_sign_s;
  logic [3:0] l_sig_s, l_eff_s;
  logic [3:0] s_sig_s, s_eff_s;
  logic       sub_s;

  // Alignment: 7-bit values laid out as {sig[3:0], guard, round, sticky}
  logic [3:0]  exp_diff_s;
  logic [13:0] align_wide_s;
  logic [6:0]  l_al_s, s_al_s;

  // Add/subtract and normalise
  logic [7:0] sum_s;
  logic [6:0] diff_s;
  logic [2:0] lz_s;
  logic [3:0] lim_s;
  logic [3:0] shamt_s;
  logic [6:0] norm_s;
  logic [4:0] norm_exp_s;
  logic       zero_s;

  // Rounding
  logic       round_up_s;
  logic [4:0] rsig_s;
  logic [4:0] fin_exp_s;
  logic [2:0] fin_man_s;
  logic       fin_hidden_s;

  // Packed result and output register
  logic [7:0] sum_byte_s;
  logic [7:0] result_r;

  // Unpack both operands into hidden-bit significands and effective exponents.
  always_comb begin
    a_sig_s = {(ui_in[6:3] != 4'd0), ui_in[2:0]};
    b_sig_s = {(uio_in[6:3] != 4'd0), uio_in[2:0]};
    a_eff_s = eff_exp(ui_in[6:3]);
    b_eff_s = eff_exp(uio_in[6:3]);
  end

  // Order operands by magnitude. The encoding is monotonic in {exp, mant},
  // so the 7-bit magnitude field compares directly.
  always_comb begin
    sub_s = ui_in[7] ^ uio_in[7];
    if (ui_in[6:0] >= uio_in[6:0]) begin
      l_sign_s = ui_in[7];
      l_sig_s  = a_sig_s;
      l_eff_s  = a_eff_s;
      s_sig_s  = b_sig_s;
      s_eff_s  = b_eff_s;
    end else begin
      l_sign_s = uio_in[7];
      l_sig_s  = b_sig_s;
      l_eff_s  = b_eff_s;
      s_sig_s  = a_sig_s;
      s_eff_s  = a_eff_s;
    end
  end

  // Right-align the smaller operand, folding shifted-out bits into sticky.
  // Shifts of 7 or more leave nothing but sticky.
  always_comb begin
    exp_diff_s   = l_eff_s - s_eff_s;
    align_wide_s = {s_sig_s, 10'd0} >> exp_diff_s;
    l_al_s       = {l_sig_s, 3'd0};
    if (exp_diff_s >= 4'd7) begin
      s_al_s = {6'd0, (s_sig_s != 4'd0)};
    end else begin
      s_al_s = {align_wide_s[13:8], align_wide_s[7] | (align_wide_s[6:0] != 7'd0)};
    end
  end

  // Add or subtract magnitudes and normalise. Subtraction only needs a
  // multi-bit left shift when the alignment shift was 0 or 1, in which case
  // the low bits are exact, so shifting the sticky position left is safe.
  always_comb begin
    sum_s      = {1'b0, l_al_s} + {1'b0, s_al_s};
    diff_s     = l_al_s - s_al_s;
    lz_s       = 3'd0;
    lim_s      = 4'd0;
    shamt_s    = 4'd0;
    norm_s     = 7'd0;
    norm_exp_s = 5'd0;
    zero_s     = 1'b0;
    if (!sub_s) begin
      zero_s = (sum_s == 8'd0);
      if (sum_s[7]) begin
        norm_s     = {sum_s[7:2], sum_s[1] | sum_s[0]};
        norm_exp_s = {1'b0, l_eff_s} + 5'd1;
      end else begin
        norm_s     = sum_s[6:0];
        norm_exp_s = {1'b0, l_eff_s};
      end
    end else begin
      zero_s = (diff_s == 7'd0);
      lz_s   = lzc7(diff_s);
      // Never normalise below effective exponent 1: gradual underflow.
      lim_s  = l_eff_s - 4'd1;
      if ({1'b0, lz_s} > lim_s) begin
        shamt_s = lim_s;
      end else begin
        shamt_s = {1'b0, lz_s};
      end
      norm_s     = diff_s << shamt_s;
      norm_exp_s = {1'b0, l_eff_s} - {1'b0, shamt_s};
    end
  end

  // Round to nearest, ties to even, on {guard, round|sticky}.
  always_comb begin
    round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    rsig_s     = {1'b0, norm_s[6:3]} + {4'd0, round_up_s};
    if (rsig_s[4]) begin
      fin_exp_s    = norm_exp_s + 5'd1;
      fin_man_s    = 3'd0;
      fin_hidden_s = 1'b1;
    end else begin
      fin_exp_s    = norm_exp_s;
      fin_man_s    = rsig_s[2:0];
      // A subnormal that rounds up to 1.000 becomes normal at exponent 1.
      fin_hidden_s = rsig_s[3];
    end
  end

  // Pack the result, handling zero sign and saturation.
  always_comb begin
    if (zero_s) begin
      // Exact cancellation gives +0; same-sign zeros keep their sign.
      if (sub_s) begin
        sum_byte_s = 8'h00;
      end else begin
        sum_byte_s = {l_sign_s, 7'd0};
      end
    end else if (fin_exp_s > 5'd15) begin
      sum_byte_s = {l_sign_s, 7'h7F};
    end else if (!fin_hidden_s) begin
      sum_byte_s = {l_sign_s, 4'd0, fin_man_s};
    end else begin
      sum_byte_s = {l_sign_s, fin_exp_s[3:0], fin_man_s};
    end
  end

  // Result register: reset wins over enable; hold when disabled.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      result_r <= 8'h00;
    end else if (ena) begin
      result_r <= sum_byte_s;
    end else begin
      result_r <= result_r;
    end
  end

  assign uo_out  = result_r;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_btflv_fp8_adder.sv
// -----------------------------------------------------------------------------
// tb_btflv_fp8_adder
//
// Directed self-checking bench for btflv_fp8_adder. Expected sums are
// hand-computed E4M3 results.
// -----------------------------------------------------------------------------
module tb_btflv_fp8_adder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  btflv_fp8_adder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input logic [7:0] obs, input logic [7:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
    end
  endtask

  // Drive one operand pair with the given controls, clock it, sample after.
  task automatic step(input logic r, input logic e, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    rst_n  = r;
    ena    = e;
    ui_in  = a;
    uio_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic add_chk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] expv, input string tag);
    step(1'b0, 1'b1, a, b);
    check8(uo_out, expv, tag);
    check8(uio_out, 8'h00, {tag, "_uio_out"});
    check8(uio_oe, 8'h00, {tag, "_uio_oe"});
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset for two cycles
    @(posedge clk);
    @(posedge clk);
    #1;
    check8(uo_out, 8'h00, "reset");
    check8(uio_oe, 8'h00, "reset_uio_oe");

    // First result one edge after release
    add_chk(8'h38, 8'h38, 8'h40, "latency_1p0_1p0");

    // Hold with ena=0
    step(1'b0, 1'b0, 8'h01, 8'h01);
    check8(uo_out, 8'h40, "hold_1");
    step(1'b0, 1'b0, 8'h78, 8'h78);
    check8(uo_out, 8'h40, "hold_2");

    // Alignment / cancellation
    add_chk(8'h3C, 8'h30, 8'h40, "align_1p5_0p5");
    add_chk(8'h38, 8'hB8, 8'h00, "cancel");
    add_chk(8'hB8, 8'h38, 8'h00, "cancel_swap");
    add_chk(8'h40, 8'hB8, 8'h38, "sub_2_m1");
    add_chk(8'hC0, 8'h38, 8'hB8, "sub_m2_1");

    // Ties-to-even
    add_chk(8'h38, 8'h18, 8'h38, "tie_even_down");
    add_chk(8'h18, 8'h38, 8'h38, "tie_even_down_swap");
    add_chk(8'h39, 8'h18, 8'h3A, "tie_even_up");
    add_chk(8'h18, 8'h39, 8'h3A, "tie_even_up_swap");

    // Far alignment collapses into sticky
    add_chk(8'h78, 8'h01, 8'h78, "sticky_add");
    add_chk(8'h78, 8'h81, 8'h78, "sticky_sub_round");

    // Subnormals
    add_chk(8'h01, 8'h01, 8'h02, "sub_sub");
    add_chk(8'h07, 8'h01, 8'h08, "sub_promote");
    add_chk(8'h08, 8'h81, 8'h07, "norm_to_sub");
    add_chk(8'h81, 8'h08, 8'h07, "norm_to_sub_swap");

    // Saturation
    add_chk(8'h7F, 8'h7F, 8'h7F, "sat_pos");
    add_chk(8'hFF, 8'hFF, 8'hFF, "sat_neg");
    add_chk(8'h78, 8'h78, 8'h7F, "sat_exp16");

    // Zeros and signs
    add_chk(8'h00, 8'h00, 8'h00, "zero_pp");
    add_chk(8'h80, 8'h80, 8'h80, "zero_nn");
    add_chk(8'h80, 8'h00, 8'h00, "zero_np");
    add_chk(8'h80, 8'h38, 8'h38, "negzero_plus_one");

    // Reset mid-stream beats enable, then first result after release
    step(1'b1, 1'b1, 8'h38, 8'h38);
    check8(uo_out, 8'h00, "reset_prio");
    add_chk(8'h40, 8'hB8, 8'h38, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
